dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 121 ++++++++++++
 tb/tb_dm_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port round-robin arbiter in front of a single-port data memory
module dm_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_rd,
    output logic              dm_wr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata
);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;      // last winner; during ACCESS it is also the owner of the access
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic elig0, elig1, win_valid, win;

    // A port holding gnt this cycle is not re-eligible, which caps a lone port at every other cycle
    assign elig0     = p0_req & ~gnt0_q;
    assign elig1     = p1_req & ~gnt1_q;
    assign win_valid = elig0 | elig1;
    assign win       = (elig0 & elig1) ? ~last_q : elig1;

    always_comb begin
        state_d     = IDLE;
        last_d      = last_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        if (state_q == ACCESS && !cmd_wr_q) begin
            if (last_q) begin
                rdata1_d  = dm_rdata;
                rvalid1_d = 1'b1;
            end else begin
                rdata0_d  = dm_rdata;
                rvalid0_d = 1'b1;
            end
        end

        if (win_valid) begin
            state_d     = ACCESS;
            last_d      = win;
            gnt0_d      = ~win;
            gnt1_d      = win;
            cmd_wr_d    = win ? p1_wr    : p0_wr;
            cmd_addr_d  = win ? p1_addr  : p0_addr;
            cmd_wdata_d = win ? p1_wdata : p0_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign p0_gnt    = gnt0_q;
    assign p1_gnt    = gnt1_q;
    assign p0_rvalid = rvalid0_q;
    assign p1_rvalid = rvalid1_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;
    assign dm_addr   = cmd_addr_q;
    assign dm_wdata  = cmd_wdata_q;
    assign dm_wr     = (state_q == ACCESS) &  cmd_wr_q;
    assign dm_rd     = (state_q == ACCESS) & ~cmd_wr_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter with a transaction-level reference model
module tb_dm_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_wr, p1_req, p1_wr;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] dm_addr;
    logic          dm_rd, dm_wr;
    logic [DW-1:0] dm_wdata, dm_rdata;

    int errors = 0;
    int checks = 0;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'hA500_0000 + 32'(a);
    endfunction

    // Memory attached to the DUT: async read, write on posedge
    logic [DW-1:0] mem [128];
    bit            seen [128];
    assign dm_rdata = seen[dm_addr] ? mem[dm_addr] : init_val(dm_addr);

    initial forever begin
        @(posedge clk);
        if (dm_wr) begin
            mem[dm_addr]  <= dm_wdata;
            seen[dm_addr] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending access, completed at the edge after it was granted
    typedef struct {
        bit          v;
        int          port;
        bit          wr;
        bit [AW-1:0] addr;
        bit [DW-1:0] wd;
    } acc_t;

    acc_t        pend;
    bit          m_gnt [2];
    bit          m_rv [2];
    bit [DW-1:0] m_rdata [2];
    int          m_last;
    bit          m_dmrd, m_dmwr;
    bit [AW-1:0] m_dmaddr;
    bit [DW-1:0] m_dmwd;
    bit [DW-1:0] mm [128];
    bit          mseen [128];
    bit          el [2];
    int          w;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            pend.v = 0;
            for (int p = 0; p < 2; p++) begin
                m_gnt[p] = 0; m_rv[p] = 0; m_rdata[p] = '0;
            end
            m_last = 1; m_dmrd = 0; m_dmwr = 0; m_dmaddr = '0; m_dmwd = '0;
        end else begin
            m_rv[0] = 0; m_rv[1] = 0;
            if (pend.v) begin
                if (pend.wr) begin
                    mm[pend.addr] = pend.wd;
                    mseen[pend.addr] = 1;
                end else begin
                    m_rdata[pend.port] = mseen[pend.addr] ? mm[pend.addr] : init_val(pend.addr);
                    m_rv[pend.port] = 1;
                end
            end
            el[0] = p0_req && !m_gnt[0];
            el[1] = p1_req && !m_gnt[1];
            if (el[0] && el[1]) w = 1 - m_last;
            else if (el[0])     w = 0;
            else if (el[1])     w = 1;
            else                w = -1;
            m_gnt[0] = 0; m_gnt[1] = 0; pend.v = 0; m_dmrd = 0; m_dmwr = 0;
            if (w >= 0) begin
                pend.v    = 1;
                pend.port = w;
                pend.wr   = (w == 0) ? p0_wr    : p1_wr;
                pend.addr = (w == 0) ? p0_addr  : p1_addr;
                pend.wd   = (w == 0) ? p0_wdata : p1_wdata;
                m_gnt[w]  = 1;
                m_last    = w;
                m_dmaddr  = pend.addr;
                m_dmwd    = pend.wd;
                m_dmwr    = pend.wr;
                m_dmrd    = !pend.wr;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("model_p0_gnt",    32'(p0_gnt),    32'(m_gnt[0]));
        chk("model_p1_gnt",    32'(p1_gnt),    32'(m_gnt[1]));
        chk("model_p0_rvalid", 32'(p0_rvalid), 32'(m_rv[0]));
        chk("model_p1_rvalid", 32'(p1_rvalid), 32'(m_rv[1]));
        chk("model_p0_rdata",  p0_rdata,       m_rdata[0]);
        chk("model_p1_rdata",  p1_rdata,       m_rdata[1]);
        chk("model_dm_rd",     32'(dm_rd),     32'(m_dmrd));
        chk("model_dm_wr",     32'(dm_wr),     32'(m_dmwr));
        chk("model_dm_addr",   32'(dm_addr),   32'(m_dmaddr));
        chk("model_dm_wdata",  dm_wdata,       m_dmwd);
        chk("gnt_exclusive",   32'(p0_gnt & p1_gnt), 32'd0);
        chk("wr_only_in_access", 32'(dm_wr & ~(p0_gnt | p1_gnt)), 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_wr = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        step();
        step();
        rst_n = 1;
    endtask

    int cnt0, cnt1;

    initial begin
        rst_n = 1;
        idle_inputs();
        #1 rst_n = 0;
        step();
        step();
        chk("rst_p0_gnt",    32'(p0_gnt),    32'd0);
        chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rst_dm_rd",     32'(dm_rd),     32'd0);
        chk("rst_dm_wr",     32'(dm_wr),     32'd0);
        chk("rst_dm_addr",   32'(dm_addr),   32'd0);
        chk("rst_p0_rdata",  p0_rdata,       32'd0);
        rst_n = 1;

        // write then read the same address from port 0
        p0_req = 1; p0_wr = 1; p0_addr = 7'd5; p0_wdata = 32'hDEADBEEF;
        step();
        chk("t30_gnt_wr",  32'(p0_gnt),  32'd1);
        chk("t30_dm_wr",   32'(dm_wr),   32'd1);
        chk("t30_dm_addr", 32'(dm_addr), 32'd5);
        p0_wr = 0;
        step();
        chk("t30_gnt_gap", 32'(p0_gnt), 32'd0);
        step();
        chk("t30_gnt_rd", 32'(p0_gnt), 32'd1);
        chk("t30_dm_rd",  32'(dm_rd),  32'd1);
        p0_req = 0;
        step();
        chk("t30_rvalid", 32'(p0_rvalid), 32'd1);
        chk("t30_rdata",  p0_rdata,       32'hDEADBEEF);
        step();
        chk("t30_rvalid_once", 32'(p0_rvalid), 32'd0);

        // simultaneous reads from reset
        do_reset();
        p0_req = 1; p0_addr = 7'd1;
        p1_req = 1; p1_addr = 7'd2;
        step();
        chk("t31_p0_first", 32'(p0_gnt), 32'd1);
        chk("t31_p1_wait",  32'(p1_gnt), 32'd0);
        p0_req = 0;
        step();
        chk("t31_p1_second", 32'(p1_gnt),    32'd1);
        chk("t31_p0_rvalid", 32'(p0_rvalid), 32'd1);
        chk("t31_p0_rdata",  p0_rdata,       32'hA5000001);
        p1_req = 0;
        step();
        chk("t31_p1_rvalid", 32'(p1_rvalid), 32'd1);
        chk("t31_p1_rdata",  p1_rdata,       32'hA5000002);
        chk("t31_p0_quiet",  32'(p0_rvalid), 32'd0);

        // continuous requests on both ports
        do_reset();
        p0_req = 1; p0_addr = 7'd10;
        p1_req = 1; p1_addr = 7'd11;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (p0_gnt) cnt0++;
            if (p1_gnt) cnt1++;
            chk($sformatf("t32_alt%0d", i), 32'(p0_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        chk("t32_split_p0", 32'(cnt0), 32'd5);
        chk("t32_split_p1", 32'(cnt1), 32'd5);
        idle_inputs();
        step();
        step();

        // tie between p0 read and p1 write to the same address
        do_reset();
        p1_req = 1; p1_wr = 1; p1_addr = 7'd127; p1_wdata = 32'h12345678;
        p0_req = 1; p0_wr = 0; p0_addr = 7'd127;
        step();
        chk("t33_p0_wins", 32'(p0_gnt), 32'd1);
        chk("t33_p1_wait", 32'(p1_gnt), 32'd0);
        p0_req = 0;
        step();
        chk("t33_p1_gnt",   32'(p1_gnt),    32'd1);
        chk("t33_p0_rv",    32'(p0_rvalid), 32'd1);
        chk("t33_old_data", p0_rdata,       32'hA500007F);
        p1_req = 0;
        p0_req = 1;
        step();
        chk("t33_p0_gnt2", 32'(p0_gnt), 32'd1);
        p0_req = 0;
        step();
        chk("t33_p0_rv2",   32'(p0_rvalid), 32'd1);
        chk("t33_new_data", p0_rdata,       32'h12345678);

        // reset in the middle of a write access
        do_reset();
        p0_req = 1; p0_wr = 1; p0_addr = 7'd3; p0_wdata = 32'hCAFEF00D;
        step();
        chk("t34_dm_wr_on", 32'(dm_wr),  32'd1);
        chk("t34_gnt_on",   32'(p0_gnt), 32'd1);
        #1 rst_n = 0;
        #1;
        chk("t34_dm_wr_async", 32'(dm_wr),   32'd0);
        chk("t34_gnt_async",   32'(p0_gnt),  32'd0);
        chk("t34_addr_async",  32'(dm_addr), 32'd0);
        idle_inputs();
        step();
        step();
        chk("t34_mem3",     seen[3] ? mem[3] : init_val(7'd3), 32'hA5000003);
        chk("t34_no_rv",    32'(p0_rvalid), 32'd0);
        rst_n = 1;
        step();
        chk("t34_no_gnt",   32'(p0_gnt),    32'd0);
        chk("t34_no_rv2",   32'(p0_rvalid), 32'd0);
        step();
        chk("t34_no_rv3",   32'(p0_rvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
